// File: rtl/alu_result_stage.sv
// ALU result stage: flag generation, a small FIFO of {data, flags} results,
// sticky carry/overflow accumulation and a free-running delivered-results counter.
module alu_result_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags,
  input  logic             clr_sticky,
  output logic             sticky_c,
  output logic             sticky_v,
  output logic [7:0]       res_cnt
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = WIDTH + 4;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [3:0]    push_flags;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full buffer refuses input even when the head is leaving this cycle.
  assign in_ready   = (count < CW'(DEPTH)) & ~rst;
  assign out_valid  = (count != '0) & ~rst;
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign push_flags = {in_data[WIDTH-1], in_data == '0, in_carry, in_ovf};
  assign {out_data, out_flags} = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_data, push_flags};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear in the same cycle as a push still records that push's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_c <= 1'b0;
      sticky_v <= 1'b0;
    end else if (clr_sticky) begin
      sticky_c <= push & in_carry;
      sticky_v <= push & in_ovf;
    end else begin
      sticky_c <= sticky_c | (push & in_carry);
      sticky_v <= sticky_v | (push & in_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (pop) begin
      res_cnt <= res_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_alu_result_stage;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_carry = 1'b0;
  logic             in_ovf = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_flags;
  logic             clr_sticky = 1'b0;
  logic             sticky_c;
  logic             sticky_v;
  logic [7:0]       res_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [3:0]       flags;
  } entry_t;

  entry_t mq[$];
  logic   m_sc = 1'b0;
  logic   m_sv = 1'b0;
  int     m_cnt = 0;
  int     m_pops = 0;

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_carry(in_carry), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags),
    .clr_sticky(clr_sticky), .sticky_c(sticky_c), .sticky_v(sticky_v),
    .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  // Flags from plain arithmetic: negative means the value is in the upper half.
  function automatic logic [3:0] model_flags(input logic [WIDTH-1:0] d, input logic c, input logic v);
    logic n, z;
    n = (int'(d) >= (1 << (WIDTH - 1)));
    z = (int'(d) == 0);
    return {n, z, c, v};
  endfunction

  function automatic logic [3:0] exp_flags();
    return (!rst && mq.size() > 0) ? mq[0].flags : 4'b0;
  endfunction

  function automatic logic [WIDTH-1:0] exp_data();
    return (!rst && mq.size() > 0) ? mq[0].data : '0;
  endfunction

  // Advance one clock, updating the model from the inputs applied this cycle.
  task automatic tick();
    bit     push, pop;
    entry_t e;
    push = (in_valid === 1'b1) && !rst && (mq.size() < DEPTH);
    pop  = !rst && (mq.size() > 0) && (out_ready === 1'b1);
    e.data  = in_data;
    e.flags = model_flags(in_data, in_carry, in_ovf);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_sc = 1'b0;
      m_sv = 1'b0;
      m_cnt = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_cnt = (m_cnt + 1) % 256;
        m_pops++;
      end
      if (push) mq.push_back(e);
      if (clr_sticky) begin
        m_sc = push && in_carry;
        m_sv = push && in_ovf;
      end else begin
        m_sc = m_sc | (push && in_carry);
        m_sv = m_sv | (push && in_ovf);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    in_carry = 1'b0; in_ovf = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks += 7;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
    if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data got=%h exp=0", out_data); end
    if (out_flags !== 4'b0) begin errors++; $display("[TB] FAIL reset_out_flags got=%b exp=0000", out_flags); end
    if (res_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_res_cnt got=%0d exp=0", res_cnt); end
    if (sticky_c !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky_c got=%b exp=0", sticky_c); end
    if (sticky_v !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky_v got=%b exp=0", sticky_v); end
    rst = 1'b0;
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_after_reset got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero_carry();
    do_reset();
    in_data = 4'h0; in_carry = 1'b1; in_ovf = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_carry = 1'b0;
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_valid got=%b exp=1", out_valid); end
    if (out_data !== 4'h0) begin errors++; $display("[TB] FAIL zero_data got=%h exp=0", out_data); end
    if (out_flags !== 4'b0110) begin errors++; $display("[TB] FAIL zero_flags got=%b exp=0110", out_flags); end
    if (sticky_c !== 1'b1) begin errors++; $display("[TB] FAIL zero_sticky_c got=%b exp=1", sticky_c); end
  endtask

  task automatic test_full_hold();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 4'h9; tick();
    in_data = 4'hA; tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready got=%b exp=0", in_ready); end
    in_data = 4'h5; tick();
    in_valid = 1'b0;
    checks += 2;
    if (out_data !== 4'h9) begin errors++; $display("[TB] FAIL full_head_data got=%h exp=9", out_data); end
    if (out_flags !== 4'b1000) begin errors++; $display("[TB] FAIL full_head_flags got=%b exp=1000", out_flags); end
    out_ready = 1'b1; tick();
    checks += 2;
    if (out_data !== 4'hA) begin errors++; $display("[TB] FAIL full_second_data got=%h exp=a", out_data); end
    if (out_flags !== 4'b1000) begin errors++; $display("[TB] FAIL full_second_flags got=%b exp=1000", out_flags); end
    tick();
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drained got=%b exp=0", out_valid); end
    if (res_cnt !== 8'd2) begin errors++; $display("[TB] FAIL full_res_cnt got=%0d exp=2", res_cnt); end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    int start;
    do_reset();
    start = m_pops;
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin
      in_data = WIDTH'($urandom); in_carry = 1'($urandom); in_ovf = 1'($urandom);
      tick();
    end
    out_ready = 1'b1;
    while (m_pops - start < 20 && guard < 100) begin
      checks += 4;
      if (out_valid !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL b2b_valid got=%b exp=%b", out_valid, mq.size() > 0); end
      if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL b2b_in_ready got=%b exp=%b", in_ready, mq.size() < DEPTH); end
      if (out_data !== exp_data()) begin errors++; $display("[TB] FAIL b2b_data got=%h exp=%h", out_data, exp_data()); end
      if (out_flags !== exp_flags()) begin errors++; $display("[TB] FAIL b2b_flags got=%b exp=%b", out_flags, exp_flags()); end
      in_data = WIDTH'($urandom); in_carry = 1'($urandom); in_ovf = 1'($urandom);
      tick();
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks += 2;
    if (guard >= 100) begin errors++; $display("[TB] FAIL b2b_timeout got=%0d pops exp=20", m_pops - start); end
    if (res_cnt !== 8'd20) begin errors++; $display("[TB] FAIL b2b_res_cnt got=%0d exp=20", res_cnt); end
  endtask

  task automatic test_sticky();
    do_reset();
    in_data = 4'h3; in_ovf = 1'b1; in_valid = 1'b1; clr_sticky = 1'b1;
    tick();
    checks++;
    if (sticky_v !== 1'b1) begin errors++; $display("[TB] FAIL sticky_push_clr got=%b exp=1", sticky_v); end
    in_valid = 1'b0; in_ovf = 1'b0;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (sticky_v !== 1'b0) begin errors++; $display("[TB] FAIL sticky_clear got=%b exp=0", sticky_v); end
  endtask

  task automatic test_res_cnt_wrap();
    int guard = 0;
    int start;
    do_reset();
    start = m_pops;
    in_data = 4'h1; in_valid = 1'b1; out_ready = 1'b1;
    while (m_pops - start < 256 && guard < 600) begin
      tick();
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks += 2;
    if (guard >= 600) begin errors++; $display("[TB] FAIL wrap_timeout got=%0d pops exp=256", m_pops - start); end
    if (res_cnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_res_cnt got=%0d exp=0", res_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; in_data = 4'h1; tick();
    in_valid = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 4'h7; tick();
    in_data = 4'h8; tick();
    in_valid = 1'b0; rst = 1'b1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready got=%b exp=0", in_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_valid got=%b exp=0", out_valid); end
    if (res_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_after_res_cnt got=%0d exp=0", res_cnt); end
    in_valid = 1'b1; in_data = 4'h3; tick();
    in_valid = 1'b0;
    checks += 2;
    if (out_data !== 4'h3) begin errors++; $display("[TB] FAIL mid_new_data got=%h exp=3", out_data); end
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_new_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_only_result got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      checks += 8;
      if (out_valid !== (!rst && mq.size() > 0)) begin errors++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, !rst && mq.size() > 0); end
      if (in_ready !== (!rst && mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, in_ready, !rst && mq.size() < DEPTH); end
      if (out_data !== exp_data()) begin errors++; $display("[TB] FAIL rnd_data cyc=%0d got=%h exp=%h", i, out_data, exp_data()); end
      if (out_flags !== exp_flags()) begin errors++; $display("[TB] FAIL rnd_flags cyc=%0d got=%b exp=%b", i, out_flags, exp_flags()); end
      if (sticky_c !== m_sc) begin errors++; $display("[TB] FAIL rnd_sticky_c cyc=%0d got=%b exp=%b", i, sticky_c, m_sc); end
      if (sticky_v !== m_sv) begin errors++; $display("[TB] FAIL rnd_sticky_v cyc=%0d got=%b exp=%b", i, sticky_v, m_sv); end
      if (res_cnt !== 8'(m_cnt)) begin errors++; $display("[TB] FAIL rnd_res_cnt cyc=%0d got=%0d exp=%0d", i, res_cnt, m_cnt); end
      if (out_valid && !out_ready && (out_data !== exp_data())) begin errors++; $display("[TB] FAIL rnd_hold cyc=%0d got=%h exp=%h", i, out_data, exp_data()); end
      rst        = ($urandom_range(0, 39) == 0);
      in_valid   = 1'($urandom);
      out_ready  = 1'($urandom);
      clr_sticky = ($urandom_range(0, 7) == 0);
      in_data    = WIDTH'($urandom);
      in_carry   = 1'($urandom);
      in_ovf     = 1'($urandom);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_carry();
    test_full_hold();
    test_back_to_back();
    test_sticky();
    test_res_cnt_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
